lfsr_sample_sequencer: RTL
==========================

// Module: lfsr_sample_sequencer
// PURPOSE
//  Sequences the 9-bit LFSR random source (0..472) for the pi simulator.
//  Seeds the LFSR and waits out its fill latency. Pairs consecutive in-range
//  values into (x,y) sample points, and hands each point downstream on a
//  valid/ready handshake. Stops after a programmed number of points.
//  Sits between the LFSR instance and the hit-test/plot logic.
// PARAMETERS
//  NUM_POINTS   1000  points per run, 1..65535
//  MAX_COORD    449   largest accepted coordinate; larger values are rejected
//  FILL_CYCLES  2     cycles after seeding before rand_in is valid, >=1
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  reset       in   1   synchronous, active-high; returns block to IDLE
//  start       in   1   begin a run; sampled only in IDLE and DONE
//  seed_in     in   8   run seed, captured on the accepted start
//  lfsr_seed   out  8   seed bus to the LFSR
//  lfsr_reset  out  1   reset/load strobe to the LFSR
//  rand_in     in   9   registered LFSR output, new value every cycle
//  pt_x        out  9   sample x coordinate
//  pt_y        out  9   sample y coordinate
//  pt_valid    out  1   pt_x/pt_y hold a point offered downstream
//  pt_ready    in   1   downstream accepts the point when pt_valid&&pt_ready
//  pt_count    out  16  points accepted in the current run
//  reject_cnt  out  16  out-of-range rand_in values discarded, saturating
//  busy        out  1   high in every state except IDLE and DONE
//  done        out  1   high in DONE
// BEHAVIOUR
//  Reset values: all outputs 0; lfsr_reset=0; state=IDLE.
//  States: IDLE, SEED, FILL, GET_X, GET_Y, OFFER, DONE.
//  IDLE/DONE --start--> SEED. On the same edge:
//    - capture seed_in;
//    - clear pt_count, reject_cnt and pt_valid.
//  Seed guard: if seed_in[4:0]==5'h1F, lfsr_seed = seed_in & 8'hFE.
//    This prevents the all-ones XNOR lockup in every sub-LFSR.
//    Otherwise lfsr_seed = seed_in. lfsr_seed holds until the next start.
//  SEED: lfsr_reset=1 for exactly 1 cycle, then go to FILL.
//  FILL: wait FILL_CYCLES cycles (down-counter), then go to GET_X.
//  GET_X:
//    - rand_in<=MAX_COORD: pt_x<=rand_in, go to GET_Y.
//    - else: reject_cnt++ and stay.
//  GET_Y:
//    - rand_in<=MAX_COORD: pt_y<=rand_in, go to OFFER, pt_valid<=1.
//    - else: reject_cnt++ and stay.
//  Compare is unsigned 9-bit. rand_in==MAX_COORD is accepted.
//  OFFER:
//    - pt_valid=1. pt_x/pt_y must not change while pt_valid && !pt_ready.
//    - On pt_valid&&pt_ready: pt_count++ and pt_valid<=0.
//    - If the new pt_count==NUM_POINTS, go to DONE; else go to GET_X.
//    - Minimum point period: 3 cycles (GET_X, GET_Y, OFFER with ready high).
//  DONE: done=1 and the counts hold until the next start or reset.
//  start while busy is ignored. It does not restart, and it does not re-capture seed_in.
//  reject_cnt saturates at 16'hFFFF. pt_count never exceeds NUM_POINTS.
//  Reset mid-run, from any state:
//    - next cycle is IDLE with all outputs 0;
//    - any pending point is dropped and not counted.
//  pt_ready while pt_valid=0 is ignored.
// TESTING
//  1. Reset, then start with seed_in=8'h3C and pt_ready=1:
//     -> lfsr_seed=8'h3C; lfsr_reset high 1 cycle;
//     -> first pt_valid no earlier than 1+FILL_CYCLES+2 cycles after SEED;
//     -> done after NUM_POINTS handshakes.
//  2. seed_in=8'hFF -> lfsr_seed=8'hFE. seed_in=8'h1F -> lfsr_seed=8'h1E.
//     seed_in=8'h0F -> lfsr_seed=8'h0F.
//  3. Drive rand_in=472,450,449,0:
//     -> reject_cnt=2, pt_x=449, pt_y=0;
//     -> 449 is accepted at the boundary.
//  4. pt_ready low for 10 cycles while pt_valid=1:
//     -> pt_x/pt_y/pt_valid stable, pt_count unchanged;
//     -> one increment when ready rises.
//  5. Assert start mid-run:
//     -> no effect on state, counts or lfsr_seed.
//     Assert reset in OFFER:
//     -> pt_valid=0, pt_count=0, done=0, state IDLE next cycle.
//  6. NUM_POINTS=3: after the 3rd handshake, done=1, busy=0, pt_count=3.
//     New start from DONE clears the counts and reseeds.

Source files
------------

// File: rtl/lfsr_sample_sequencer_if.sv
// Point stream from the sample sequencer to the hit-test/plot logic.
// The master owns the coordinates and valid; the slave owns ready.
interface lfsr_sample_sequencer_if;
    logic [8:0] pt_x;
    logic [8:0] pt_y;
    logic       pt_valid;
    logic       pt_ready;

    modport master (output pt_x, output pt_y, output pt_valid, input pt_ready);
    modport slave  (input pt_x, input pt_y, input pt_valid, output pt_ready);
endinterface

// File: rtl/lfsr_sample_sequencer.sv
// Seeds the 9-bit LFSR, waits out its fill latency, pairs in-range values into
// (x,y) points and offers each on a valid/ready stream until NUM_POINTS are taken.
module lfsr_sample_sequencer #(
    parameter int unsigned NUM_POINTS  = 1000,
    parameter int unsigned MAX_COORD   = 449,
    parameter int unsigned FILL_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    seed_in,
    output logic [7:0]                    lfsr_seed,
    output logic                          lfsr_reset,
    input  logic [8:0]                    rand_in,
    lfsr_sample_sequencer_if.master       pt,
    output logic [15:0]                   pt_count,
    output logic [15:0]                   reject_cnt,
    output logic                          busy,
    output logic                          done
);

    localparam logic [8:0]  MAX_C     = 9'(MAX_COORD);
    localparam logic [15:0] NUM_P     = 16'(NUM_POINTS);
    localparam logic [15:0] FILL_LAST = 16'(FILL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_FILL, S_GET_X, S_GET_Y, S_OFFER, S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] fill_q;
    logic [7:0]  lfsr_seed_q;
    logic        lfsr_reset_q;
    logic [8:0]  pt_x_q;
    logic [8:0]  pt_y_q;
    logic        pt_valid_q;
    logic [15:0] pt_count_q;
    logic [15:0] reject_cnt_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  seed_d;
    logic [15:0] pt_count_d;
    logic [15:0] reject_cnt_d;
    logic        rand_ok;

    // An all-ones low field would lock every XNOR sub-LFSR; clearing bit 0 avoids it.
    always_comb begin
        seed_d       = (seed_in[4:0] == 5'h1F) ? (seed_in & 8'hFE) : seed_in;
        pt_count_d   = pt_count_q + 16'd1;
        reject_cnt_d = (reject_cnt_q == '1) ? reject_cnt_q : reject_cnt_q + 16'd1;
        rand_ok      = (rand_in <= MAX_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fill_q       <= '0;
            lfsr_seed_q  <= '0;
            lfsr_reset_q <= 1'b0;
            pt_x_q       <= '0;
            pt_y_q       <= '0;
            pt_valid_q   <= 1'b0;
            pt_count_q   <= '0;
            reject_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_SEED;
                        lfsr_seed_q  <= seed_d;
                        lfsr_reset_q <= 1'b1;
                        pt_count_q   <= '0;
                        reject_cnt_q <= '0;
                        pt_valid_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                    end
                end
                S_SEED: begin
                    lfsr_reset_q <= 1'b0;
                    fill_q       <= FILL_LAST;
                    state_q      <= S_FILL;
                end
                S_FILL: begin
                    if (fill_q == '0) begin
                        state_q <= S_GET_X;
                    end else begin
                        fill_q <= fill_q - 16'd1;
                    end
                end
                S_GET_X: begin
                    if (rand_ok) begin
                        pt_x_q  <= rand_in;
                        state_q <= S_GET_Y;
                    end else begin
                        reject_cnt_q <= reject_cnt_d;
                    end
                end
                S_GET_Y: begin
                    if (rand_ok) begin
                        pt_y_q     <= rand_in;
                        pt_valid_q <= 1'b1;
                        state_q    <= S_OFFER;
                    end else begin
                        reject_cnt_q <= reject_cnt_d;
                    end
                end
                S_OFFER: begin
                    if (pt.pt_ready) begin
                        pt_count_q <= pt_count_d;
                        pt_valid_q <= 1'b0;
                        if (pt_count_d == NUM_P) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_GET_X;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lfsr_seed   = lfsr_seed_q;
    assign lfsr_reset  = lfsr_reset_q;
    assign pt.pt_x     = pt_x_q;
    assign pt.pt_y     = pt_y_q;
    assign pt.pt_valid = pt_valid_q;
    assign pt_count    = pt_count_q;
    assign reject_cnt  = reject_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
